// File: rtl/waveform_sequencer.sv
// waveform_sequencer: step sequencer feeding octave/waveform/note of
// waveform_gen from a small pattern memory, with gated articulation.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   start, stop     begin playback from step 0 / abort playback
//   loop            wrap after last_step (sampled at step boundary)
//   last_step       final step index (latched on start)
//   load_en/addr/   pattern write port {wave[8:7], octave[6:4], note[3:0]},
//   load_data       accepted only while idle
//   octave,waveform,note  registered step fields (waveform one-hot)
//   gate            high while the current note sounds
//   step_idx        step currently playing
//   busy, done      playback active / one-clock end-of-pass pulse

module waveform_sequencer #(
   parameter int clk_mhz     = 50,
   parameter int n_steps     = 8,
   parameter int w_waveform  = 4,
   parameter int step_cycles = clk_mhz * 1000 * 250,
   parameter int gap_cycles  = clk_mhz * 1000 * 25,
   parameter int w_idx       = $clog2(n_steps)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop,
   input  logic [w_idx-1:0]      last_step,
   input  logic                  load_en,
   input  logic [w_idx-1:0]      load_addr,
   input  logic [8:0]            load_data,
   output logic [2:0]            octave,
   output logic [w_waveform-1:0] waveform,
   output logic [3:0]            note,
   output logic                  gate,
   output logic [w_idx-1:0]      step_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int w_cnt = $clog2(step_cycles);
   localparam int depth = 2 ** w_idx;

   localparam logic [w_cnt-1:0] play_end =
      w_cnt'(step_cycles - gap_cycles - 1);
   localparam logic [w_cnt-1:0] gap_end =
      w_cnt'(gap_cycles - 1);
   localparam logic [8:0] rest_word = 9'b11_000_0000;

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      GAP
   } state_t;

   state_t           state, state_n;
   logic [w_cnt-1:0] cnt, cnt_n;
   logic [w_idx-1:0] last_q, last_n;
   logic [8:0]       mem [depth];

   logic [2:0]            oct_n;
   logic [w_waveform-1:0] wave_n;
   logic [3:0]            note_n;
   logic                  gate_n;
   logic [w_idx-1:0]      idx_n;
   logic                  busy_n;
   logic                  done_n;

   logic [w_idx-1:0] ld_idx;
   logic [8:0]       ld_word;
   logic             ld_rest;

   // Index of the step that would be loaded on this edge: step 0 when
   // starting from idle, otherwise the successor with wrap at last_q.
   always_comb begin
      ld_idx = '0;
      if (state != IDLE && step_idx != last_q)
         ld_idx = step_idx + w_idx'(1);
   end

   assign ld_word = mem[ld_idx];
   assign ld_rest = (ld_word[8:7] == 2'd3) || (ld_word[3:0] >= 4'd12);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last_q;
      oct_n   = octave;
      wave_n  = waveform;
      note_n  = note;
      gate_n  = gate;
      idx_n   = step_idx;
      busy_n  = busy;
      done_n  = 1'b0;

      if (stop) begin
         state_n = IDLE;
         cnt_n   = '0;
         gate_n  = 1'b0;
         busy_n  = 1'b0;
         wave_n  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_n = PLAY;
                  cnt_n   = '0;
                  last_n  = last_step;
                  idx_n   = '0;
                  busy_n  = 1'b1;
               end
            end
            PLAY: begin
               if (cnt == play_end) begin
                  state_n = GAP;
                  cnt_n   = '0;
                  gate_n  = 1'b0;
               end else begin
                  cnt_n = cnt + w_cnt'(1);
               end
            end
            GAP: begin
               if (cnt == gap_end) begin
                  cnt_n = '0;
                  if (step_idx != last_q || loop) begin
                     state_n = PLAY;
                     idx_n   = ld_idx;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                     done_n  = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + w_cnt'(1);
               end
            end
            default: state_n = IDLE;
         endcase
      end

      // Field load coincides with entry to PLAY so the new fields and
      // the gate rise appear in the same cycle.
      if (state_n == PLAY && state != PLAY) begin
         if (ld_rest) begin
            oct_n  = '0;
            wave_n = '0;
            note_n = '0;
            gate_n = 1'b0;
         end else begin
            oct_n  = ld_word[6:4];
            wave_n = '0;
            wave_n[ld_word[8:7]] = 1'b1;
            note_n = ld_word[3:0];
            gate_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         last_q   <= '0;
         octave   <= '0;
         waveform <= '0;
         note     <= '0;
         gate     <= 1'b0;
         step_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int i = 0; i < depth; i++)
            mem[i] <= rest_word;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         last_q   <= last_n;
         octave   <= oct_n;
         waveform <= wave_n;
         note     <= note_n;
         gate     <= gate_n;
         step_idx <= idx_n;
         busy     <= busy_n;
         done     <= done_n;
         if (load_en && !busy && int'(load_addr) < n_steps)
            mem[load_addr] <= load_data;
      end
   end

endmodule
